// File: rtl/cpld_bank_pkg.sv
// rtl/cpld_bank_pkg.sv - shared types and constants for the bank select capture block
// Purpose : FSM state encoding plus the select tag and ramblock reset value.
// Ports   : none (package).
package cpld_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_QUAL     = 2'd1,
    ST_WAIT_END = 2'd2,
    ST_COMMIT   = 2'd3
  } bank_state_t;

  // data[7:6] value that marks a write as a RAM bank/scheme selection
  localparam logic [1:0] SELECT_TAG     = 2'b11;
  localparam logic [5:0] RAMBLOCK_RESET = 6'b0;

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - single-bit multi-flop synchroniser with reset preset
// Purpose : bring one asynchronous control input into the clk domain.
// Ports   : clk   - destination clock
//           reset - asynchronous active-high reset, presets every flop to RESET_VAL
//           d     - asynchronous input
//           q     - synchronised output, DEPTH clk edges behind d
module sync_bit #(
  parameter int   DEPTH     = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= {DEPTH{RESET_VAL}};
    end else begin
      chain <= {chain[DEPTH-2:0], d};
    end
  end

  assign q = chain[DEPTH-1];

endmodule

// File: rtl/bank_select_capture.sv
// rtl/bank_select_capture.sv - captures Z80 writes to port 0x7FXX into a RAM bank select
// Purpose : synchronise the Z80 control strobes, filter the write strobe, sample
//           the data bus and commit {ccc,bbb} to the RAM mapper once the write ends.
// Ports   : clk        - system clock
//           reset      - asynchronous active-high reset
//           iorq_b     - Z80 I/O request (active low, async)
//           wr_b       - Z80 write strobe (active low, async)
//           adr15      - Z80 address bit 15 (low selects 0x7FXX)
//           data       - Z80 data bus (sampled only while the strobe is stable)
//           busreset_b - expansion-bus reset (active low, async)
//           ramblock   - committed bank/scheme value
//           commit     - one-cycle pulse when ramblock is updated
//           ignored    - one-cycle pulse when a non-select write completes
//           busy       - FSM is not idle
module bank_select_capture
  import cpld_bank_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iorq_b,
  input  logic       wr_b,
  input  logic       adr15,
  input  logic [7:0] data,
  input  logic       busreset_b,
  output logic [5:0] ramblock,
  output logic       commit,
  output logic       ignored,
  output logic       busy
);

  localparam int               CNT_W    = $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] FILT_MAX = CNT_W'(FILTER_CYCLES);

  logic iorq_s, wr_s, adr15_s, busreset_s;
  logic strobe;

  bank_state_t      state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [7:0]       data_q, data_n;
  logic [5:0]       ramblock_q, ramblock_n;
  logic             commit_q, commit_n;
  logic             ignored_q, ignored_n;

  // Presets match the idle level of each pin so reset never fakes a strobe.
  sync_bit #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_iorq (
    .clk(clk), .reset(reset), .d(iorq_b), .q(iorq_s)
  );
  sync_bit #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_wr (
    .clk(clk), .reset(reset), .d(wr_b), .q(wr_s)
  );
  sync_bit #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_adr15 (
    .clk(clk), .reset(reset), .d(adr15), .q(adr15_s)
  );
  sync_bit #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_busreset (
    .clk(clk), .reset(reset), .d(busreset_b), .q(busreset_s)
  );

  assign strobe = !iorq_s && !wr_s && !adr15_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      data_q     <= '0;
      ramblock_q <= RAMBLOCK_RESET;
      commit_q   <= 1'b0;
      ignored_q  <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      data_q     <= data_n;
      ramblock_q <= ramblock_n;
      commit_q   <= commit_n;
      ignored_q  <= ignored_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    data_n     = data_q;
    ramblock_n = ramblock_q;
    commit_n   = 1'b0;
    ignored_n  = 1'b0;

    // Bus reset wins over everything, including a pending COMMIT.
    if (!busreset_s) begin
      state_n    = ST_IDLE;
      cnt_n      = '0;
      ramblock_n = RAMBLOCK_RESET;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (strobe) begin
            state_n = ST_QUAL;
            cnt_n   = CNT_W'(1);
          end
        end
        ST_QUAL: begin
          if (!strobe) begin
            state_n = ST_IDLE;
          end else if (cnt_q == FILT_MAX) begin
            data_n  = data;
            state_n = ST_WAIT_END;
          end else if (cnt_q < FILT_MAX) begin
            cnt_n = cnt_q + CNT_W'(1);
          end
        end
        // Held here until the strobe ends, so a long write yields one pulse.
        ST_WAIT_END: begin
          if (!strobe) begin
            if (data_q[7:6] == SELECT_TAG) begin
              state_n = ST_COMMIT;
            end else begin
              ignored_n = 1'b1;
              state_n   = ST_IDLE;
            end
          end
        end
        ST_COMMIT: begin
          ramblock_n = data_q[5:0];
          commit_n   = 1'b1;
          state_n    = ST_IDLE;
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  assign ramblock = ramblock_q;
  assign commit   = commit_q;
  assign ignored  = ignored_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bank_select_capture.sv
// tb/tb_bank_select_capture.sv - directed self-checking bench for bank_select_capture
module tb_bank_select_capture;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       iorq_b = 1'b1;
  logic       wr_b = 1'b1;
  logic       adr15 = 1'b1;
  logic [7:0] data = 8'h00;
  logic       busreset_b = 1'b1;
  logic [5:0] ramblock;
  logic       commit;
  logic       ignored;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int commit_cnt = 0;
  int ignored_cnt = 0;
  int c0, i0;

  bank_select_capture #(.SYNC_STAGES(2), .FILTER_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .iorq_b(iorq_b), .wr_b(wr_b), .adr15(adr15),
    .data(data), .busreset_b(busreset_b), .ramblock(ramblock),
    .commit(commit), .ignored(ignored), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (commit === 1'b1) commit_cnt++;
    if (ignored === 1'b1) ignored_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic strobe_on, input logic a15, input logic [7:0] d);
    iorq_b = !strobe_on;
    wr_b   = !strobe_on;
    adr15  = a15;
    data   = d;
  endtask

  // Full write: strobe held n cycles, released, then enough idle time to finish.
  task automatic write_cycle(input logic [7:0] d, input int n);
    drive(1'b1, 1'b0, d);
    tick(n);
    drive(1'b0, 1'b1, d);
    tick(8);
  endtask

  initial begin
    // Reset state
    tick(2);
    check("rst_ramblock", {2'b0, ramblock}, 8'h00);
    check("rst_commit", {7'b0, commit}, 8'h00);
    check("rst_ignored", {7'b0, ignored}, 8'h00);
    check("rst_busy", {7'b0, busy}, 8'h00);
    reset = 1'b0;
    tick(3);

    // Select write 0xD2, commit exactly on the 4th edge after release is sampled
    c0 = commit_cnt;
    drive(1'b1, 1'b0, 8'hD2);
    tick(4);
    check("d2_busy", {7'b0, busy}, 8'h01);
    drive(1'b0, 1'b1, 8'hD2);
    tick(3);
    check("d2_early_commit", {7'b0, commit}, 8'h00);
    check("d2_early_ramblock", {2'b0, ramblock}, 8'h00);
    tick(1);
    check("d2_commit", {7'b0, commit}, 8'h01);
    check("d2_ramblock", {2'b0, ramblock}, 8'h12);
    tick(1);
    check("d2_commit_end", {7'b0, commit}, 8'h00);
    check("d2_busy_end", {7'b0, busy}, 8'h00);
    tick(3);
    check_int("d2_commit_count", commit_cnt - c0, 1);

    // Same value again still commits
    c0 = commit_cnt;
    write_cycle(8'hD2, 4);
    check_int("d2_repeat_commit", commit_cnt - c0, 1);
    check("d2_repeat_ramblock", {2'b0, ramblock}, 8'h12);

    // Long strobe yields one pulse only
    c0 = commit_cnt;
    write_cycle(8'hDB, 20);
    check_int("long_commit_count", commit_cnt - c0, 1);
    check("long_ramblock", {2'b0, ramblock}, 8'h1B);
    write_cycle(8'hD2, 4);

    // Non-select tag: ignored pulse, ramblock kept
    c0 = commit_cnt;
    i0 = ignored_cnt;
    write_cycle(8'h8C, 4);
    check_int("8c_ignored_count", ignored_cnt - i0, 1);
    check_int("8c_commit_count", commit_cnt - c0, 0);
    check("8c_ramblock", {2'b0, ramblock}, 8'h12);

    // One-cycle glitch rejected
    c0 = commit_cnt;
    i0 = ignored_cnt;
    drive(1'b1, 1'b0, 8'hFF);
    tick(1);
    drive(1'b0, 1'b1, 8'hFF);
    tick(8);
    check_int("glitch_commit_count", commit_cnt - c0, 0);
    check_int("glitch_ignored_count", ignored_cnt - i0, 0);
    check("glitch_busy", {7'b0, busy}, 8'h00);
    check("glitch_ramblock", {2'b0, ramblock}, 8'h12);

    // adr15 high: not our port
    c0 = commit_cnt;
    i0 = ignored_cnt;
    drive(1'b1, 1'b1, 8'hC5);
    tick(4);
    check("a15_busy", {7'b0, busy}, 8'h00);
    drive(1'b0, 1'b1, 8'hC5);
    tick(8);
    check("a15_busy_after", {7'b0, busy}, 8'h00);
    check_int("a15_pulses", (commit_cnt - c0) + (ignored_cnt - i0), 0);
    check("a15_ramblock", {2'b0, ramblock}, 8'h12);

    // Commit 0xFF, then bus reset during a 0xC9 write
    write_cycle(8'hFF, 4);
    check("ff_ramblock", {2'b0, ramblock}, 8'h3F);
    c0 = commit_cnt;
    drive(1'b1, 1'b0, 8'hC9);
    tick(4);
    busreset_b = 1'b0;
    tick(3);
    drive(1'b0, 1'b1, 8'hC9);
    busreset_b = 1'b1;
    tick(10);
    check("busrst_ramblock", {2'b0, ramblock}, 8'h00);
    check_int("busrst_commit_count", commit_cnt - c0, 0);
    check("busrst_busy", {7'b0, busy}, 8'h00);

    // Reset while in WAIT_END holding 0xC7
    write_cycle(8'hE5, 4);
    check("e5_ramblock", {2'b0, ramblock}, 8'h25);
    c0 = commit_cnt;
    drive(1'b1, 1'b0, 8'hC7);
    tick(5);
    check("c7_wait_busy", {7'b0, busy}, 8'h01);
    reset = 1'b1;
    #1;
    check("mid_rst_ramblock", {2'b0, ramblock}, 8'h00);
    check("mid_rst_busy", {7'b0, busy}, 8'h00);
    check("mid_rst_commit", {7'b0, commit}, 8'h00);
    check("mid_rst_ignored", {7'b0, ignored}, 8'h00);
    tick(2);
    drive(1'b0, 1'b1, 8'hC7);
    reset = 1'b0;
    tick(10);
    check("post_rst_ramblock", {2'b0, ramblock}, 8'h00);
    check_int("post_rst_commit_count", commit_cnt - c0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bank_select_capture.md
BANK_SELECT_CAPTURE -- requirements
Module: bank_select_capture

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth for the asynchronous Z80 control inputs (minimum 2).
REQ-002 SHALL have parameter FILTER_CYCLES, default 2: consecutive clk cycles the qualified write strobe must hold before data is sampled (minimum 1).
REQ-003 SHALL have port clk, input, 1: single system clock for all state.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port iorq_b, input, 1: Z80 I/O request, active low, asynchronous to clk.
REQ-006 SHALL have port wr_b, input, 1: Z80 write strobe, active low, asynchronous.
REQ-007 SHALL have port adr15, input, 1: Z80 address bit 15; a low value selects port 0x7FXX.
REQ-008 SHALL have port data, input, 8: Z80 data bus.
REQ-009 SHALL have port busreset_b, input, 1: expansion-bus reset, active low, asynchronous.
REQ-010 SHALL have port ramblock, output, 6: committed bank/scheme value {ccc,bbb} for the downstream RAM mapper.
REQ-011 SHALL have port commit, output, 1: one-cycle pulse in the cycle ramblock is updated.
REQ-012 SHALL have port ignored, output, 1: one-cycle pulse when a qualified 0x7FXX write completes with data[7:6] != 2'b11.
REQ-013 SHALL have port busy, output, 1: high whenever the FSM is not in IDLE.

Function
REQ-014 SHALL pass iorq_b, wr_b, adr15 and busreset_b each through a SYNC_STAGES flop chain before use; data SHALL NOT be synchronised.
REQ-015 SHALL form strobe = !iorq_s & !wr_s & !adr15_s from the synchronised signals.
REQ-016 SHALL implement FSM states IDLE, QUAL, WAIT_END and COMMIT.
REQ-017 In IDLE, when strobe = 1, the FSM SHALL go to QUAL and load the filter counter with 1.
REQ-018 In QUAL, when strobe = 0, the FSM SHALL return to IDLE with no pulse (glitch rejection).
REQ-019 In QUAL, when strobe = 1 and the counter equals FILTER_CYCLES, the block SHALL latch data into data_q and go to WAIT_END; otherwise it SHALL increment the counter.
REQ-020 In WAIT_END, when strobe = 0, the FSM SHALL go to COMMIT if data_q[7:6] = 2'b11; otherwise it SHALL pulse ignored and go to IDLE.
REQ-021 In COMMIT, the block SHALL load ramblock with data_q[5:0], pulse commit and go to IDLE in that same single cycle.
REQ-022 A strobe held for any length SHALL produce at most one commit or ignored pulse; a new write SHALL be recognised only after a return to IDLE.
REQ-023 The filter counter SHALL be wide enough for FILTER_CYCLES and SHALL saturate, never wrap.
REQ-024 Latency SHALL be exactly SYNC_STAGES+2 clk edges, counted from the first edge that samples the strobe deasserted at the pins to the edge that updates ramblock and raises commit.
REQ-025 When busreset_s = 0, the block SHALL clear ramblock to 6'b0 and force the FSM to IDLE on the next edge, with priority over a COMMIT in the same cycle; commit SHALL stay 0 in that case.
REQ-026 While busreset_s = 0, the FSM SHALL remain in IDLE and ignore strobe.
REQ-027 Writing the same value twice SHALL still produce a commit pulse each time.

Reset
REQ-028 When reset = 1, the block SHALL immediately set ramblock = 6'b0, commit = 0, ignored = 0, busy = 0, state = IDLE, counter = 0 and data_q = 0.
REQ-029 Reset SHALL preset all synchroniser flops to the inactive level: 1 for iorq_b, wr_b and busreset_b, and 0 for adr15.
REQ-030 Reset asserted mid-operation, in QUAL, WAIT_END or COMMIT, SHALL abort the operation with no commit pulse.

Structure
REQ-031 A shared package cpld_bank_pkg SHALL hold the FSM state enumeration, SELECT_TAG = 2'b11 and RAMBLOCK_RESET = 6'b0.
REQ-032 The synchroniser SHALL be a sub-module named sync_bit, with parameters for depth and reset value, instantiated once per control input.

Verification
REQ-033 Write 8'hD2 (iorq_b=0, wr_b=0, adr15=0) for 4 cycles, then release: ramblock SHALL become 6'h12 with one commit pulse exactly 4 edges after the release is sampled (defaults).
REQ-034 Write 8'h8C for 4 cycles: ignored SHALL pulse once and ramblock SHALL keep its previous value.
REQ-035 Apply a 1-cycle strobe carrying 8'hFF: there SHALL be no commit and no ignored pulse, busy SHALL return to 0 and ramblock SHALL be unchanged.
REQ-036 Write 8'hC5 with adr15=1: the FSM SHALL stay in IDLE and there SHALL be no pulses.
REQ-037 Commit 8'hFF, then pull busreset_b low for 3 cycles while a write of 8'hC9 is in progress: ramblock SHALL become 6'h00 and there SHALL be no commit for 8'hC9.
REQ-038 Assert reset while the FSM is in WAIT_END holding data 8'hC7: all outputs SHALL go to 0 immediately, and after release ramblock SHALL stay 6'h00.
